// File: rtl/io_write_fifo_pkg.sv
// Shared I/O port-adapter constants: default word width, write slack and
// Empty/Full polarity seen by the core.
package io_write_fifo_pkg;

    localparam int unsigned IO_WORD_WIDTH = 36;
    localparam int unsigned IO_ADDR_WIDTH = 4;
    localparam int unsigned IO_DEPTH      = 16;
    localparam int unsigned IO_SLACK      = 8;

    // Core-facing Empty/Full encoding: 0 lets the core issue a write.
    typedef enum logic {
        IO_EF_READY = 1'b0,
        IO_EF_FULL  = 1'b1
    } io_ef_e;

    // EF decode: flag the port full once the free entries can no longer
    // absorb writes that already passed the core's EF check.
    function automatic io_ef_e io_ef_decode(
        input logic [31:0] free_entries,
        input logic [31:0] slack
    );
        io_ef_e ef_v;
        if (free_entries <= slack) begin
            ef_v = IO_EF_FULL;
        end else begin
            ef_v = IO_EF_READY;
        end
        return ef_v;
    endfunction

endpackage

// File: rtl/io_fifo_ram.sv
// Simple dual-port buffer storage: one synchronous write port, one
// combinational read port addressed by the FIFO read pointer.
module io_fifo_ram
    import io_write_fifo_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = IO_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = IO_ADDR_WIDTH,
    parameter int unsigned DEPTH      = IO_DEPTH
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem_r [DEPTH];

    // Write port: contents are deliberately never cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/io_write_fifo.sv
// Core-to-external write buffer: accepts core I/O writes, presents them in
// order to a ready/valid consumer and signals Empty/Full back to the core.
module io_write_fifo
    import io_write_fifo_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = IO_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = IO_ADDR_WIDTH,
    parameter int unsigned DEPTH      = IO_DEPTH,
    parameter int unsigned SLACK      = IO_SLACK
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_wren,
    input  logic [WORD_WIDTH-1:0] io_write_data,
    output logic                  io_write_EF,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  overflow_r;

    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  ram_we_s;
    logic [ADDR_WIDTH:0]   free_s;

    // Handshake decode; a full buffer still accepts a write when a pop
    // frees an entry on the same edge.
    always_comb begin
        full_s   = 1'b0;
        pop_s    = 1'b0;
        push_s   = 1'b0;
        drop_s   = 1'b0;
        ram_we_s = 1'b0;
        free_s   = DEPTH_C - count_r;
        if (count_r == DEPTH_C) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        pop_s    = (count_r != {(ADDR_WIDTH+1){1'b0}}) && out_ready;
        push_s   = io_wren && (!full_s || pop_s);
        drop_s   = io_wren && full_s && !pop_s;
        ram_we_s = push_s && !reset;
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            count_r    <= {(ADDR_WIDTH+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    io_fifo_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we_s),
        .wr_addr (wr_ptr_r),
        .wr_data (io_write_data),
        .rd_addr (rd_ptr_r),
        .rd_data (out_data)
    );

    assign fill_count  = count_r;
    assign out_valid   = (count_r != {(ADDR_WIDTH+1){1'b0}});
    assign overflow    = overflow_r;
    assign io_write_EF = io_ef_decode(32'(free_s), 32'(SLACK));

endmodule

// File: tb/tb_io_write_fifo.sv
// Directed bench for io_write_fifo: reset, EF slack threshold, ordered drain,
// overflow drop, pointer wrap streaming and reset mid-operation.
module tb_io_write_fifo;

    logic        clock;
    logic        reset;
    logic        io_wren;
    logic [35:0] io_write_data;
    logic        io_write_EF;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fill_count;
    logic        overflow;

    int tests_run;
    int tests_failed;

    io_write_fifo dut (
        .clock         (clock),
        .reset         (reset),
        .io_wren       (io_wren),
        .io_write_data (io_write_data),
        .io_write_EF   (io_write_EF),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fill_count    (fill_count),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; inputs change and outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; io_wren = 1'b0; out_ready = 1'b0; io_write_data = 36'h0;
        step();
        step();
        reset = 1'b0;
        step();
        tests_run++; if (fill_count !== 5'd0) begin tests_failed++; $display("FAIL reset_fill got %0d want 0", fill_count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests_run++; if (io_write_EF !== 1'b0) begin tests_failed++; $display("FAIL reset_ef got %b want 0", io_write_EF); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", overflow); end
    endtask

    task automatic test_fill_ef();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            io_wren = 1'b1; io_write_data = 36'(i);
            step();
            tests_run++; if (fill_count !== 5'(i)) begin tests_failed++; $display("FAIL fill_count push %0d got %0d want %0d", i, fill_count, i); end
            tests_run++; if (io_write_EF !== (i >= 8)) begin tests_failed++; $display("FAIL fill_ef push %0d got %b want %b", i, io_write_EF, (i >= 8)); end
        end
        io_wren = 1'b0;
        step();
        tests_run++; if (fill_count !== 5'd8) begin tests_failed++; $display("FAIL fill_hold got %0d want 8", fill_count); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_valid word %0d got %b want 1", i, out_valid); end
            tests_run++; if (out_data !== 36'(i)) begin tests_failed++; $display("FAIL drain_data word %0d got %h want %h", i, out_data, 36'(i)); end
            tests_run++; if (io_write_EF !== ((9 - i) >= 8)) begin tests_failed++; $display("FAIL drain_ef word %0d got %b want %b", i, io_write_EF, ((9 - i) >= 8)); end
            step();
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_valid got %b want 0", out_valid); end
        tests_run++; if (fill_count !== 5'd0) begin tests_failed++; $display("FAIL drain_empty_fill got %0d want 0", fill_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            io_wren = 1'b1; io_write_data = 36'h200 + 36'(i);
            step();
        end
        tests_run++; if (fill_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_full got %0d want 16", fill_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_pre got %b want 0", overflow); end
        tests_run++; if (io_write_EF !== 1'b1) begin tests_failed++; $display("FAIL ovf_ef got %b want 1", io_write_EF); end
        io_write_data = 36'h99;
        step();
        tests_run++; if (fill_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_drop_fill got %0d want 16", fill_count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b want 1", overflow); end
        tests_run++; if (out_data !== 36'h200) begin tests_failed++; $display("FAIL ovf_head got %h want 200", out_data); end
        io_write_data = 36'hAA; out_ready = 1'b1;
        step();
        tests_run++; if (fill_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_swap_fill got %0d want 16", fill_count); end
        io_wren = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tests_run++;
            if (i < 16) begin
                if (out_data !== 36'h200 + 36'(i)) begin tests_failed++; $display("FAIL ovf_order word %0d got %h want %h", i, out_data, 36'h200 + 36'(i)); end
            end else begin
                if (out_data !== 36'hAA) begin tests_failed++; $display("FAIL ovf_order word %0d got %h want aa", i, out_data); end
            end
            step();
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained got %b want 0", out_valid); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            io_wren = 1'b1; io_write_data = 36'h100 + 36'(i);
            step();
            tests_run++; if (out_data !== 36'h100 + 36'(i)) begin tests_failed++; $display("FAIL stream_data word %0d got %h want %h", i, out_data, 36'h100 + 36'(i)); end
            tests_run++; if (fill_count !== 5'd1) begin tests_failed++; $display("FAIL stream_fill word %0d got %0d want 1", i, fill_count); end
            tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL stream_ovf word %0d got %b want 0", i, overflow); end
        end
        io_wren = 1'b0;
        step();
        tests_run++; if (fill_count !== 5'd0) begin tests_failed++; $display("FAIL stream_end got %0d want 0", fill_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            io_wren = 1'b1; io_write_data = 36'h300 + 36'(i);
            step();
        end
        io_wren = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
        end
        out_ready = 1'b0;
        tests_run++; if (fill_count !== 5'd5) begin tests_failed++; $display("FAIL mid_pre_fill got %0d want 5", fill_count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_ovf got %b want 1", overflow); end
        tests_run++; if (out_data !== 36'h30B) begin tests_failed++; $display("FAIL mid_pre_head got %h want 30b", out_data); end
        reset = 1'b1; io_wren = 1'b1; io_write_data = 36'h5A5;
        step();
        reset = 1'b0; io_wren = 1'b0;
        tests_run++; if (fill_count !== 5'd0) begin tests_failed++; $display("FAIL mid_fill got %0d want 0", fill_count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b want 0", out_valid); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_ovf got %b want 0", overflow); end
        tests_run++; if (io_write_EF !== 1'b0) begin tests_failed++; $display("FAIL mid_ef got %b want 0", io_write_EF); end
        step();
        tests_run++; if (fill_count !== 5'd0) begin tests_failed++; $display("FAIL mid_absent got %0d want 0", fill_count); end
        io_wren = 1'b1; io_write_data = 36'h777;
        step();
        io_wren = 1'b0;
        tests_run++; if (out_data !== 36'h777) begin tests_failed++; $display("FAIL mid_restart got %h want 777", out_data); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fill_ef();
        test_drain();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
